// File: rtl/cmsdk_mcu_pmu_ctrl_pkg.sv
// Shared state encodings and widths for the PMU sequencer.
package cmsdk_mcu_pmu_ctrl_pkg;

  localparam int PMU_ST_W = 3;

  // Codes 5-7 are unused and recover to RUN.
  typedef enum logic [PMU_ST_W-1:0] {
    PMU_ST_RUN   = 3'd0,
    PMU_ST_HOLD  = 3'd1,
    PMU_ST_GATED = 3'd2,
    PMU_ST_WAKE  = 3'd3,
    PMU_ST_RST   = 3'd4
  } pmu_state_e;

endpackage

// File: rtl/cmsdk_mcu_pmu_cnt.sv
// Loadable saturating down-counter shared by the wake delay and reset stretch.
module cmsdk_mcu_pmu_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // A load wins over a decrement; the count stops at zero and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cmsdk_mcu_pmu_ctrl.sv
// PMU sequencer: deep-sleep handshake, HCLK/DCLK gate enables and reset stretching.
// Runs on free-running FCLK; every output is a flop fed from the next-state decode.
module cmsdk_mcu_pmu_ctrl
  import cmsdk_mcu_pmu_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int WAKE_DLY        = 4,
  parameter int CNT_W           = 5,
  parameter int DBG_RST_EN      = 0
) (
  input  logic                FCLK,
  input  logic                PORESETn,
  input  logic                PMUENABLE,
  input  logic                SLEEPING,
  input  logic                SLEEPDEEP,
  input  logic                SLEEPHOLDACKn,
  input  logic                WAKEUP,
  input  logic                SYSRESETREQ,
  input  logic                CDBGPWRUPREQ,
  output logic                HCLKEN,
  output logic                DCLKEN,
  output logic                SLEEPHOLDREQn,
  output logic                PMUHRESETREQ,
  output logic                PMUDBGRESETREQ,
  output logic                CDBGPWRUPACK,
  output logic [PMU_ST_W-1:0] PMU_STATE
);

  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_DLY - 1);

  pmu_state_e       state, nxt;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             nxt_hclken, nxt_holdn, nxt_hrst;

  cmsdk_mcu_pmu_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (FCLK),
    .rst_n    (PORESETn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Next state and counter control; a reset request overrides any sleep/wake activity.
  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    if (SYSRESETREQ) begin
      nxt      = PMU_ST_RST;
      cnt_load = 1'b1;
      cnt_val  = RST_LD;
    end else begin
      case (state)
        PMU_ST_RUN:   if (SLEEPING && SLEEPDEEP && PMUENABLE) nxt = PMU_ST_HOLD;
        PMU_ST_HOLD:  if (WAKEUP || !SLEEPING) nxt = PMU_ST_RUN;    // abort beats ack
                      else if (!SLEEPHOLDACKn) nxt = PMU_ST_GATED;
        PMU_ST_GATED: if (WAKEUP) begin
                        nxt      = PMU_ST_WAKE;
                        cnt_load = 1'b1;
                        cnt_val  = WAKE_LD;
                      end
        PMU_ST_WAKE,
        PMU_ST_RST:   if (cnt_zero) nxt = PMU_ST_RUN;
                      else          cnt_dec = 1'b1;
        default:      nxt = PMU_ST_RUN;
      endcase
    end
  end

  // Outputs are a function of the state being entered, so they change on the same edge.
  always_comb begin
    nxt_hclken = (nxt != PMU_ST_GATED);
    nxt_holdn  = (nxt == PMU_ST_RUN) || (nxt == PMU_ST_RST);
    nxt_hrst   = (nxt == PMU_ST_RST);
  end

  // State and output registers, all returned to RUN values by power-on reset.
  always_ff @(posedge FCLK or negedge PORESETn) begin
    if (!PORESETn) begin
      state          <= PMU_ST_RUN;
      HCLKEN         <= 1'b1;
      DCLKEN         <= 1'b1;
      SLEEPHOLDREQn  <= 1'b1;
      PMUHRESETREQ   <= 1'b0;
      PMUDBGRESETREQ <= 1'b0;
      CDBGPWRUPACK   <= 1'b0;
    end else begin
      state          <= nxt;
      HCLKEN         <= nxt_hclken;
      DCLKEN         <= nxt_hclken | CDBGPWRUPREQ;  // debugger keeps DCLK alive in GATED
      SLEEPHOLDREQn  <= nxt_holdn;
      PMUHRESETREQ   <= nxt_hrst;
      PMUDBGRESETREQ <= (DBG_RST_EN != 0) ? nxt_hrst : 1'b0;
      CDBGPWRUPACK   <= CDBGPWRUPREQ;
    end
  end

  assign PMU_STATE = state;

endmodule
